wb_stream_master: RTL and testbench

//   Wishbone initiator driven by a byte-stream command protocol. It is the

---
 rtl/wb_stream_master_pkg.sv | 31 +++
 rtl/wb_stream_master_if.sv | 37 +++
 rtl/wb_stream_master.sv | 163 ++++++++++++++++
 tb/tb_wb_stream_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stream_master_pkg.sv
// ============================================================================
// Module : wb_stream_master_pkg
// Brief  : Opcodes, response codes and FSM state encodings for wb_stream_master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_stream_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_ADDR = 3'd1;
  localparam state_t ST_MASK = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_BUS  = 3'd4;
  localparam state_t ST_RESP = 3'd5;

  function automatic logic is_cmd(input logic [7:0] op);
    return (op == CMD_WR) || (op == CMD_RD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_stream_master_if.sv
// ============================================================================
// Module : wb_stream_master_if
// Brief  : Command/response byte streams plus the single-slave bus they drive.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_stream_master_if #(
  parameter int WB_AW = 16,
  parameter int WB_DW = 32
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic [WB_AW-1:0]   wb_addr;
  logic [WB_DW-1:0]   wb_wdata;
  logic [WB_DW/8-1:0] wb_wmsk;
  logic               wb_we;
  logic               wb_cyc;
  logic [WB_DW-1:0]   wb_rdata;
  logic               wb_ack;

  modport master (
    input  in_data, in_valid, out_ready, wb_rdata, wb_ack,
    output in_ready, out_data, out_valid, wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc
  );

  modport slave (
    output in_data, in_valid, out_ready, wb_rdata, wb_ack,
    input  in_ready, out_data, out_valid, wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc
  );
endinterface

`default_nettype wire

// File: rtl/wb_stream_master.sv
// ============================================================================
// Module : wb_stream_master
// Brief  : Byte-stream command decoder that runs single bus read/write cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stream_master
  import wb_stream_master_pkg::*;
#(
  parameter int WB_AW     = 16,
  parameter int WB_DW     = 32,
  parameter int TIMEOUT_W = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  wb_stream_master_if.master bus,
  output logic               busy
);

  localparam logic [TIMEOUT_W-1:0] c_tmo_last = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] c_tmo_one  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_idx;
  logic                 r_we;
  logic                 r_err;
  logic                 r_ok;
  logic                 r_cyc;
  logic [15:0]          r_addr;
  logic [WB_DW-1:0]     r_wdata;
  logic [WB_DW-1:0]     r_rdata;
  logic [3:0]           r_wmsk;
  logic [TIMEOUT_W-1:0] r_tmo;

  logic       w_in_ready;
  logic       w_out_valid;
  logic [7:0] w_out_data;
  logic       w_busy;
  logic       w_in_fire;
  logic       w_out_fire;
  logic       w_tmo_hit;
  logic       w_bus_done;
  logic [2:0] w_last_idx;
  logic       w_resp_done;

  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;
  assign w_tmo_hit   = (r_tmo == c_tmo_last);
  assign w_bus_done  = r_cyc & (bus.wb_ack | w_tmo_hit);
  // Only a successful read carries the four data bytes after the status byte.
  assign w_last_idx  = (r_ok & ~r_we & ~r_err) ? 3'd4 : 3'd0;
  assign w_resp_done = w_out_fire & (r_idx == w_last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_in_fire) w_next = is_cmd(bus.in_data) ? ST_ADDR : ST_RESP;
      ST_ADDR: if (w_in_fire && r_idx == 3'd1) w_next = r_we ? ST_MASK : ST_BUS;
      ST_MASK: if (w_in_fire) w_next = ST_DATA;
      ST_DATA: if (w_in_fire && r_idx == 3'd3) w_next = ST_BUS;
      ST_BUS:  if (w_bus_done) w_next = ST_RESP;
      ST_RESP: if (w_resp_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = rst_n & ((r_state == ST_IDLE) | (r_state == ST_ADDR) |
                           (r_state == ST_MASK) | (r_state == ST_DATA));
    w_out_valid = (r_state == ST_RESP);
    w_busy      = (r_state != ST_IDLE);
    w_out_data  = 8'h00;
    if (r_state == ST_RESP) begin
      if (r_err)      w_out_data = RSP_ERR;
      else if (!r_ok) w_out_data = RSP_NAK;
      else begin
        case (r_idx)
          3'd1:    w_out_data = r_rdata[31:24];
          3'd2:    w_out_data = r_rdata[23:16];
          3'd3:    w_out_data = r_rdata[15:8];
          3'd4:    w_out_data = r_rdata[7:0];
          default: w_out_data = RSP_ACK;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= 3'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_ok    <= 1'b0;
      r_cyc   <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wmsk  <= 4'h0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_in_fire) begin
          r_we   <= (bus.in_data == CMD_WR);
          r_err  <= ~is_cmd(bus.in_data);
          r_ok   <= 1'b0;
          r_wmsk <= 4'h0;
          r_idx  <= 3'd0;
        end
        ST_ADDR: if (w_in_fire) begin
          r_addr <= {r_addr[7:0], bus.in_data};
          r_idx  <= (r_idx == 3'd1) ? 3'd0 : r_idx + 3'd1;
          if (r_idx == 3'd1 && !r_we) begin
            r_cyc <= 1'b1;
            r_tmo <= '0;
          end
        end
        ST_MASK: if (w_in_fire) r_wmsk <= bus.in_data[3:0];
        ST_DATA: if (w_in_fire) begin
          r_wdata <= {r_wdata[WB_DW-9:0], bus.in_data};
          r_idx   <= (r_idx == 3'd3) ? 3'd0 : r_idx + 3'd1;
          if (r_idx == 3'd3) begin
            r_cyc <= 1'b1;
            r_tmo <= '0;
          end
        end
        // An ack on the timeout cycle still wins.
        ST_BUS: begin
          if (bus.wb_ack) begin
            r_cyc   <= 1'b0;
            r_ok    <= 1'b1;
            r_rdata <= bus.wb_rdata;
          end else if (w_tmo_hit) begin
            r_cyc <= 1'b0;
          end else begin
            r_tmo <= r_tmo + c_tmo_one;
          end
        end
        ST_RESP: if (w_out_fire) r_idx <= w_resp_done ? 3'd0 : r_idx + 3'd1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.wb_addr   = r_addr[WB_AW-1:0];
  assign bus.wb_wdata  = r_wdata;
  assign bus.wb_wmsk   = r_wmsk;
  assign bus.wb_we     = r_we;
  assign bus.wb_cyc    = r_cyc;
  assign busy          = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_wb_stream_master.sv
// ============================================================================
// Module : tb_wb_stream_master
// Brief  : Self-checking bench: directed vector table, reset sequences, random traffic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_stream_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  wb_stream_master_if #(.WB_AW(16), .WB_DW(32)) bus ();

  wb_stream_master #(.WB_AW(16), .WB_DW(32), .TIMEOUT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  a1;
    logic [7:0]  a0;
    logic [7:0]  m;
    logic [31:0] wd;
    int          ack_at;
    logic [31:0] rd;
    int          ex_cyc;
    logic [15:0] ex_addr;
    logic [31:0] ex_wd;
    logic [3:0]  ex_msk;
    logic        ex_we;
    int          ex_len;
    logic [39:0] ex_bytes;
  } vec_t;

  vec_t tbl[8];

  int n_checks = 0;
  int n_errors = 0;
  int viol;
  int cyc_n;
  logic [15:0] g_addr;
  logic [31:0] g_wd;
  logic [3:0]  g_msk;
  logic        g_we;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          m_cyc;
  logic [15:0] m_addr;
  logic [31:0] m_wd;
  logic [3:0]  m_msk;
  logic        m_we;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: expected bus transaction and response bytes from the wire-format rules.
  function automatic void model(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a0,
                                input logic [7:0] m, input logic [31:0] wd, input int ack_at,
                                input logic [31:0] rd);
    bit cmd = (op == 8'h57) || (op == 8'h52);
    bit ok  = (ack_at >= 1) && (ack_at <= 255);
    exp_q.delete();
    m_addr = {a1, a0};
    m_we   = (op == 8'h57);
    m_msk  = m_we ? m[3:0] : 4'h0;
    m_wd   = wd;
    if (!cmd) begin
      m_cyc = 0;
      exp_q.push_back(8'h3F);
    end else begin
      m_cyc = ok ? ack_at : 255;
      if (!ok) exp_q.push_back(8'h15);
      else begin
        exp_q.push_back(8'h06);
        if (!m_we) for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int gap;
    bit acc;
    gap = $urandom_range(0, 2);
    acc = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    check("send_accept", acc, 1);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] op, input logic [7:0] a1,
                         input logic [7:0] a0, input logic [7:0] m, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] rd, input int rdy_pct);
    bit         pend;
    logic [7:0] pd;
    bit         cmd;
    viol = 0;
    cmd  = (op == 8'h57) || (op == 8'h52);
    send_byte(op);
    if (cmd) begin
      send_byte(a1);
      send_byte(a0);
      if (op == 8'h57) begin
        send_byte(m);
        for (int i = 3; i >= 0; i--) send_byte(wd[8*i +: 8]);
      end
    end
    check({tag, "_cyc_rise"}, bus.wb_cyc, cmd);
    cyc_n = 0;
    for (int k = 0; k < 300; k++) begin
      if (!bus.wb_cyc) break;
      cyc_n++;
      if (cyc_n == 1) begin
        g_addr = bus.wb_addr; g_wd = bus.wb_wdata; g_msk = bus.wb_wmsk; g_we = bus.wb_we;
      end else if (bus.wb_addr !== g_addr || bus.wb_wdata !== g_wd ||
                   bus.wb_wmsk !== g_msk || bus.wb_we !== g_we) viol++;
      if (!busy || bus.in_ready) viol++;
      bus.wb_ack   = (cyc_n == ack_at);
      bus.wb_rdata = bus.wb_ack ? rd : $urandom;
      @(posedge clk); #1;
      bus.wb_ack   = 1'b0;
      bus.wb_rdata = $urandom;
    end
    check({tag, "_resp_start"}, bus.out_valid, 1);
    got_q.delete();
    pend = 1'b0;
    pd   = 8'h00;
    for (int k = 0; k < 300 && got_q.size() < exp_q.size(); k++) begin
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (pend && (!bus.out_valid || bus.out_data !== pd)) viol++;
      if (!busy || bus.in_ready) viol++;
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      pend = bus.out_valid && !bus.out_ready;
      pd   = bus.out_data;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    check({tag, "_idle_after"}, {busy, bus.out_valid, bus.in_ready}, 3'b001);
  endtask

  task automatic compare(input string tag);
    check({tag, "_cyc_cycles"}, cyc_n, m_cyc);
    if (m_cyc > 0) begin
      check({tag, "_addr"}, g_addr, m_addr);
      check({tag, "_we"}, g_we, m_we);
      check({tag, "_wmsk"}, g_msk, m_msk);
      if (m_we) check({tag, "_wdata"}, g_wd, m_wd);
    end
    check({tag, "_resp_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_resp%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_protocol"}, viol, 0);
  endtask

  task automatic run_vec(input int i, input string tag);
    exp_q.delete();
    for (int b = 0; b < tbl[i].ex_len; b++)
      exp_q.push_back(tbl[i].ex_bytes[8*(tbl[i].ex_len-1-b) +: 8]);
    m_cyc = tbl[i].ex_cyc; m_addr = tbl[i].ex_addr; m_wd = tbl[i].ex_wd;
    m_msk = tbl[i].ex_msk; m_we = tbl[i].ex_we;
    run_txn(tag, tbl[i].op, tbl[i].a1, tbl[i].a0, tbl[i].m, tbl[i].wd,
            tbl[i].ack_at, tbl[i].rd, 70);
    compare(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h57, 8'h00, 8'h12, 8'h0F, 32'hDEADBEEF, 3, 32'h0, 3, 16'h0012, 32'hDEADBEEF, 4'hF, 1'b1, 1, 40'h06};
    tbl[1] = '{8'h52, 8'h01, 8'h00, 8'h00, 32'h0, 1, 32'h12345678, 1, 16'h0100, 32'h0, 4'h0, 1'b0, 5, 40'h0612345678};
    tbl[2] = '{8'h52, 8'hAB, 8'hCD, 8'h00, 32'h0, 0, 32'h0, 255, 16'hABCD, 32'h0, 4'h0, 1'b0, 1, 40'h15};
    tbl[3] = '{8'h52, 8'h00, 8'h01, 8'h00, 32'h0, 255, 32'hCAFEF00D, 255, 16'h0001, 32'h0, 4'h0, 1'b0, 5, 40'h06CAFEF00D};
    tbl[4] = '{8'hAA, 8'h00, 8'h00, 8'h00, 32'h0, 0, 32'h0, 0, 16'h0, 32'h0, 4'h0, 1'b0, 1, 40'h3F};
    tbl[5] = '{8'h52, 8'h00, 8'h02, 8'h00, 32'h0, 2, 32'h0A0B0C0D, 2, 16'h0002, 32'h0, 4'h0, 1'b0, 5, 40'h060A0B0C0D};
    tbl[6] = '{8'h57, 8'hFF, 8'hFF, 8'h00, 32'h01020304, 1, 32'h0, 1, 16'hFFFF, 32'h01020304, 4'h0, 1'b1, 1, 40'h06};
    tbl[7] = '{8'h57, 8'h12, 8'h34, 8'hF5, 32'h55AA55AA, 0, 32'h0, 255, 16'h1234, 32'h55AA55AA, 4'h5, 1'b1, 1, 40'h15};

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    bus.wb_ack    = 1'b0;
    bus.wb_rdata  = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_outputs", {bus.wb_cyc, bus.out_valid, bus.wb_we, bus.wb_wmsk, busy,
                          bus.out_data, bus.wb_addr, bus.wb_wdata}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", {bus.in_ready, busy}, 2'b10);

    for (int i = 0; i < 8; i++) run_vec(i, $sformatf("vec%0d", i));

    // Reset asserted while a write is on the bus, then a clean write.
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h20); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (5) begin @(posedge clk); #1; end
    check("midrst_cyc_pre", bus.wb_cyc, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_async", {bus.wb_cyc, bus.out_valid, busy, bus.in_ready}, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("midrst_held", {bus.wb_cyc, bus.out_valid}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(0, "post_rst");

    for (int t = 0; t < 40; t++) begin
      logic [7:0]  op, a1, a0, m;
      logic [31:0] wd, rd;
      int          sel, ack_at;
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? 8'h57 : (sel < 8) ? 8'h52 : 8'($urandom_range(0, 255));
      if (op == 8'h57 || op == 8'h52) op = (sel < 4) ? 8'h57 : (sel < 8) ? 8'h52 : 8'h00;
      a1 = 8'($urandom); a0 = 8'($urandom); m = 8'($urandom);
      wd = $urandom; rd = $urandom;
      ack_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      model(op, a1, a0, m, wd, ack_at, rd);
      run_txn($sformatf("rnd%0d", t), op, a1, a0, m, wd, ack_at, rd, $urandom_range(20, 100));
      compare($sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
